r2sdf_stage: RTL and testbench
==============================

// Module: r2sdf_stage
// PURPOSE
//  Radix-2 single-path delay-feedback (R2SDF) butterfly stage of the 16-point streaming FFT.
//  Accepts one complex sample per valid cycle and performs the add/subtract butterfly across a
//  D-deep feedback delay line. Emits each result with the twiddle index that the downstream
//  twiddle ROM + rotator pair needs. One instance per stage; stage STAGE feeds rotator STAGE.
// PARAMETERS
//  DATA_WIDTH  12  width of each real/imag component (two's complement)
//  N_LOG2      4   log2 of FFT size (16 points)
//  STAGE       1   stage index, 1..N_LOG2; delay depth D = 2**(N_LOG2-STAGE)
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               asynchronous, active-high reset
//  in_valid   in   1               in_r/in_i hold a sample this cycle
//  in_r       in   DATA_WIDTH      input real, Q fraction bits F_in = DATA_WIDTH-STAGE-1
//  in_i       in   DATA_WIDTH      input imag, same format
//  out_valid  out  1               out_* hold a sample this cycle
//  out_sop    out  1               first sample of an output frame
//  out_r      out  DATA_WIDTH      output real, fraction bits F_in-1 (binary point moves, no bit growth)
//  out_i      out  DATA_WIDTH      output imag
//  tw_addr    out  N_LOG2-1        twiddle index k for W_N^k, to twiddle ROM feeding rotator
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_sop=0, out_r=out_i=0, tw_addr=0.
//    Counter cleared, delay line zeroed, FSM enters PRIME. Reset mid-frame discards the partial frame.
//  - All state advances only on in_valid=1. in_valid=0 freezes the counter, delay line and FSM.
//    On such a cycle out_valid=0 next cycle and out_r/out_i/tw_addr hold their values.
//  - Counter cnt: log2(2D) bits, increments per accepted sample and wraps 2D-1 -> 0.
//    Define ph = cnt[MSB] and j = cnt mod D.
//  - FSM states: PRIME, FILL, BFLY.
//    PRIME: first D accepted samples after reset; samples shift into the delay line; out_valid stays 0.
//    PRIME -> BFLY when j wraps D-1 -> 0.
//    BFLY (ph=1): let dl = delay head and x = input.
//      out = (dl + x) >>> 1; delay line is written with (x_dl - x) >>> 1, i.e. (dl - x) >>> 1.
//      tw_addr = 0. out_sop = 1 when j = 0.
//    BFLY -> FILL on wrap.
//    FILL (ph=0): out = delay head (a stored difference); delay line is written with x.
//      tw_addr = j * 2**(STAGE-1). FILL -> BFLY on wrap.
//  - Arithmetic: sum/difference are formed at DATA_WIDTH+1 bits. The result takes bits [DATA_WIDTH:1]
//    (floor, arithmetic shift), so it never overflows and never saturates.
//  - Latency: outputs are registered one clk after the accepting edge. Sums of frame m appear in
//    frame m's second half. Differences of frame m appear in the first half of frame m+1; the
//    final frame is drained by driving one zero frame.
//  - Simultaneous rst and in_valid: reset wins; the sample is dropped.
// STRUCTURE
//  - fft_pkg: DATA_WIDTH and N_LOG2 constants, typedef cplx_t {logic signed [DATA_WIDTH-1:0] r,i;},
//    and function tw_index(j, stage).
//  - Sub-module sdf_delay_line #(DEPTH, WIDTH): enable-gated shift register of cplx_t, async reset
//    to zero, head output, tail write.
//  - Top level holds the counter, the FSM, the butterfly adders and the output registers.
// TESTING (STAGE=1, D=8, DATA_WIDTH=12; 1.0 = 12'h400 at input)
//  1 Impulse frame x0=12'h200, x1..15=0, then a zero frame -> sums out: 12'h100 then 7x 0, with
//    tw_addr=0 and out_sop on the first; then diffs: 12'h100 at tw_addr 0, then 0s at tw_addr 1..7.
//  2 Constant frame, all 12'h100 (imag 0), then a zero frame -> 8 sums = 12'h100; all 8 diffs = 0.
//  3 Repeat test 1 with in_valid toggling 1,0,1,0 -> identical out_valid-qualified sequence;
//    out_* hold on idle cycles.
//  4 Extremes: dl=12'h7FF, x=12'h7FF -> sum 12'h7FF, diff 0.
//    dl=12'h800, x=12'h7FF -> diff 12'h800 (-2048).
//    dl=12'hFFF, x=0 -> sum 12'hFFF (floor of -0.5 LSB).
//  5 rst pulse after 5 accepted samples, asynchronous between edges -> all outputs 0 immediately;
//    the next 8 samples give out_valid=0 (PRIME).
//  6 Random frames vs a golden radix-2 DIF model -> bit-exact out_r/out_i/tw_addr per sample;
//    report pass/fail counts.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample type, FSM states and twiddle indexing for the streaming FFT
package fft_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int N_LOG2 = 4;
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] r;
    logic signed [DATA_WIDTH-1:0] i;
  } cplx_t;
  typedef enum logic [1:0] {PRIME, FILL, BFLY} sdf_state_t;
  function automatic int unsigned tw_index(input int unsigned j, input int unsigned stage);
    return j << (stage - 1);
  endfunction
endpackage

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: enable-gated shift register, written at the tail and read at the head
module sdf_delay_line #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] wr,
  output logic [WIDTH-1:0] head
);
  logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;
  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d[0] = wr;
      for (int k = 1; k < DEPTH; k++) sr_d[k] = sr_q[k-1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '0;
    else sr_q <= sr_d;
  assign head = sr_q[DEPTH-1];
endmodule

// File: rtl/r2sdf_stage.sv
// r2sdf_stage: radix-2 single-path delay-feedback butterfly stage with twiddle index output
module r2sdf_stage #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int N_LOG2 = fft_pkg::N_LOG2,
  parameter int STAGE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [N_LOG2-2:0]     tw_addr
);
  import fft_pkg::*;
  localparam int D = 2 ** (N_LOG2 - STAGE);
  localparam int CW = N_LOG2 - STAGE + 1;
  localparam int TW = N_LOG2 - 1;
  localparam logic [CW-1:0] J_MAX = CW'(D - 1);
  sdf_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, j;
  logic wrap;
  logic out_valid_q, out_valid_d, out_sop_q, out_sop_d;
  logic [DATA_WIDTH-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
  logic [TW-1:0] tw_q, tw_d;
  logic [2*DATA_WIDTH-1:0] head, wr;
  logic [DATA_WIDTH-1:0] dl_r, dl_i, sum_r, sum_i, dif_r, dif_i;
  // Sum/difference at DATA_WIDTH+1 bits, keep the top DATA_WIDTH bits (floor halving)
  function automatic logic [DATA_WIDTH-1:0] halve(input logic signed [DATA_WIDTH:0] v);
    return DATA_WIDTH'(v >>> 1);
  endfunction
  assign {dl_r, dl_i} = head;
  assign j = cnt_q & J_MAX;
  assign wrap = j == J_MAX;
  assign sum_r = halve({dl_r[DATA_WIDTH-1], dl_r} + {in_r[DATA_WIDTH-1], in_r});
  assign sum_i = halve({dl_i[DATA_WIDTH-1], dl_i} + {in_i[DATA_WIDTH-1], in_i});
  assign dif_r = halve({dl_r[DATA_WIDTH-1], dl_r} - {in_r[DATA_WIDTH-1], in_r});
  assign dif_i = halve({dl_i[DATA_WIDTH-1], dl_i} - {in_i[DATA_WIDTH-1], in_i});
  // Butterfly half feeds differences back; priming and fill halves store the raw input
  assign wr = state_q == BFLY ? {dif_r, dif_i} : {in_r, in_i};
  sdf_delay_line #(.DEPTH(D), .WIDTH(2 * DATA_WIDTH)) u_dl (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .wr  (wr),
    .head(head)
  );
  always_comb begin
    cnt_d = in_valid ? cnt_q + CW'(1) : cnt_q;
    state_d = !(in_valid && wrap) ? state_q : state_q == BFLY ? FILL : BFLY;
    out_valid_d = in_valid && state_q != PRIME;
    out_sop_d = in_valid && state_q == BFLY && j == '0;
    out_r_d = !out_valid_d ? out_r_q : state_q == BFLY ? sum_r : dl_r;
    out_i_d = !out_valid_d ? out_i_q : state_q == BFLY ? sum_i : dl_i;
    tw_d = !out_valid_d ? tw_q : state_q == BFLY ? '0 : TW'(tw_index(32'(j), 32'(STAGE)));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= PRIME;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_r_q <= '0;
      out_i_q <= '0;
      tw_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sop_q <= out_sop_d;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
      tw_q <= tw_d;
    end
  assign out_valid = out_valid_q;
  assign out_sop = out_sop_q;
  assign out_r = out_r_q;
  assign out_i = out_i_q;
  assign tw_addr = tw_q;
endmodule

// File: tb/tb_r2sdf_stage.sv
// tb_r2sdf_stage: directed and random checks of the stage-1 R2SDF butterfly against a frame-level DIF model
`timescale 1ns/1ps
module tb_r2sdf_stage;
  import fft_pkg::*;
  typedef struct {
    logic [11:0] r;
    logic [11:0] i;
    logic [2:0]  tw;
    logic        sop;
  } rec_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [11:0] in_r = '0, in_i = '0;
  logic out_valid, out_sop;
  logic [11:0] out_r, out_i;
  logic [2:0] tw_addr;
  int checks = 0, errors = 0;
  cplx_t cur[16], prev[16];
  int pos = 0;
  bit have_prev = 0;
  rec_t last, obs[$];
  logic [11:0] vec[16];

  r2sdf_stage #(.DATA_WIDTH(12), .N_LOG2(4), .STAGE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_sop(out_sop), .out_r(out_r), .out_i(out_i), .tw_addr(tw_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] half(input logic [11:0] a, input logic [11:0] b, input bit sub);
    int s;
    s = sub ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    return 12'(s >>> 1);
  endfunction

  // Sums of a frame leave during its second half; differences during the next frame's first half
  task automatic send(input logic v, input logic [11:0] r, input logic [11:0] i);
    rec_t e;
    bit ev;
    ev = 0;
    e = last;
    e.sop = 1'b0;
    in_valid = v; in_r = r; in_i = i;
    if (v) begin
      cur[pos] = {r, i};
      if (pos >= 8) begin
        e = '{r: half(cur[pos-8].r, r, 0), i: half(cur[pos-8].i, i, 0), tw: 3'd0, sop: 1'(pos == 8)};
        ev = 1;
      end else if (have_prev) begin
        e = '{r: half(prev[pos].r, prev[pos+8].r, 1), i: half(prev[pos].i, prev[pos+8].i, 1),
              tw: 3'(pos), sop: 1'b0};
        ev = 1;
      end
      pos++;
      if (pos == 16) begin
        prev = cur;
        have_prev = 1;
        pos = 0;
      end
    end
    @(posedge clk); #1;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_sop", 32'(out_sop), 32'(e.sop));
    check("out_r", 32'(out_r), 32'(e.r));
    check("out_i", 32'(out_i), 32'(e.i));
    check("tw_addr", 32'(tw_addr), 32'(e.tw));
    if (ev) begin
      last = e;
      obs.push_back('{out_r, out_i, tw_addr, out_sop});
    end
  endtask

  task automatic pulse_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sop", 32'(out_sop), 0);
    check("rst_r", 32'(out_r), 0);
    check("rst_i", 32'(out_i), 0);
    check("rst_tw", 32'(tw_addr), 0);
    @(posedge clk); #1 rst = 1'b0;
    pos = 0;
    have_prev = 0;
    last = '{default: '0};
    obs.delete();
  endtask

  task automatic zero_frame();
    for (int n = 0; n < 16; n++) send(1'b1, 12'h000, 12'h000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    last = '{default: '0};
    @(posedge clk); #1;
    pulse_reset();
    // Impulse frame then a zero frame
    for (int n = 0; n < 16; n++) send(1'b1, n == 0 ? 12'h200 : 12'h000, 12'h000);
    zero_frame();
    check("t1_count", obs.size(), 24);
    check("t1_sum0", 32'(obs[0].r), 32'h100);
    check("t1_sop0", 32'(obs[0].sop), 1);
    check("t1_sum1", 32'(obs[1].r), 0);
    check("t1_dif0", 32'(obs[8].r), 32'h100);
    check("t1_dif0_tw", 32'(obs[8].tw), 0);
    check("t1_dif1_tw", 32'(obs[9].tw), 1);
    check("t1_dif7_tw", 32'(obs[15].tw), 7);
    check("t1_dif7", 32'(obs[15].r), 0);
    // Constant frame
    pulse_reset();
    for (int n = 0; n < 16; n++) send(1'b1, 12'h100, 12'h000);
    zero_frame();
    check("t2_sum0", 32'(obs[0].r), 32'h100);
    check("t2_sum7", 32'(obs[7].r), 32'h100);
    check("t2_dif0", 32'(obs[8].r), 0);
    check("t2_dif7", 32'(obs[15].r), 0);
    // Impulse again with idle cycles between every sample
    pulse_reset();
    for (int n = 0; n < 32; n++) begin
      send(1'b1, n == 0 ? 12'h200 : 12'h000, 12'h000);
      send(1'b0, 12'h5A5, 12'h3C3);
    end
    check("t3_count", obs.size(), 24);
    check("t3_sum0", 32'(obs[0].r), 32'h100);
    check("t3_dif0", 32'(obs[8].r), 32'h100);
    check("t3_dif7_tw", 32'(obs[15].tw), 7);
    // Extremes
    pulse_reset();
    for (int n = 0; n < 16; n++) vec[n] = 12'h000;
    vec[0] = 12'h7FF; vec[8] = 12'h7FF;
    vec[1] = 12'h800; vec[9] = 12'h7FF;
    vec[2] = 12'hFFF; vec[10] = 12'h000;
    for (int n = 0; n < 16; n++) send(1'b1, vec[n], 12'h000);
    zero_frame();
    check("t4_sum_max", 32'(obs[0].r), 32'h7FF);
    check("t4_sum_neg_half", 32'(obs[2].r), 32'hFFF);
    check("t4_dif_zero", 32'(obs[8].r), 0);
    check("t4_dif_min", 32'(obs[9].r), 32'h800);
    // Mid-frame asynchronous reset with in_valid held high
    pulse_reset();
    for (int n = 0; n < 16; n++) send(1'b1, n < 8 ? 12'h100 : 12'h000, n < 8 ? 12'h040 : 12'h000);
    for (int n = 0; n < 5; n++) send(1'b1, 12'h000, 12'h000);
    check("t5_pre_r", 32'(obs[obs.size()-1].r), 32'h080);
    check("t5_pre_i", 32'(obs[obs.size()-1].i), 32'h020);
    pulse_reset();
    for (int n = 0; n < 16; n++) send(1'b1, 12'h123, 12'h321);
    check("t5_count", obs.size(), 8);
    // Random frames with random idle gaps
    pulse_reset();
    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 16; n++) begin
        if ($urandom_range(0, 3) == 0) send(1'b0, 12'($urandom), 12'($urandom));
        send(1'b1, 12'($urandom), 12'($urandom));
      end
    zero_frame();
    check("t6_count", obs.size(), 72);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
